// File: rtl/led3_control.sv
// Three-channel PWM driver for four RGB LEDs: eight buttons latch one of eight
// preset colours, and a free-running 8-bit counter sets each channel's duty.

module led3_counter (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of how the processes are ordered.
  always_ff @(posedge clk) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt + 8'd1;
  end

endmodule

module led3_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn,
  output logic [3:0] led_signal_R,
  output logic [3:0] led_signal_G,
  output logic [3:0] led_signal_B
);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } colour_t;

  logic [7:0] cnt;
  colour_t    state;
  colour_t    next_state;

  led3_counter c1 (
    .clk (clk),
    .rst (rst),
    .cnt (cnt)
  );

  // Lowest set button wins; no button held keeps the latched colour.
  always_comb begin
    // NOTE: the hold value is assigned first so no path through the case
    // leaves next_state unassigned, which would infer a latch.
    next_state = state;
    casez (btn)
      8'b???????1: next_state = 24'hFF0000;
      8'b??????10: next_state = 24'hFF8000;
      8'b?????100: next_state = 24'hFFFF00;
      8'b????1000: next_state = 24'h00FF00;
      8'b???10000: next_state = 24'h0000FF;
      8'b??100000: next_state = 24'h4B0082;
      8'b?1000000: next_state = 24'h800080;
      8'b10000000: next_state = 24'hFFFFFF;
      default:     next_state = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= '0;
    else      state <= next_state;
  end

  // Registered compare: high for cnt in [0, ref), so ref=255 drops only at cnt=255.
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_signal_R <= '0;
      led_signal_G <= '0;
      led_signal_B <= '0;
    end else begin
      led_signal_R <= {4{cnt < state.r}};
      led_signal_G <= {4{cnt < state.g}};
      led_signal_B <= {4{cnt < state.b}};
    end
  end

endmodule

// File: tb/tb_led3_control.sv
// Bench for led3_control: a cycle-level colour/PWM model checked every cycle,
// plus literal duty counts and register values for each preset.

module tb_led3_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] btn;
  logic [3:0] led_r, led_g, led_b;

  int checks = 0;
  int passes = 0;

  led3_control dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .led_signal_R (led_r),
    .led_signal_G (led_g),
    .led_signal_B (led_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] presets [8];
  initial begin
    presets[0] = 24'hFF0000; presets[1] = 24'hFF8000;
    presets[2] = 24'hFFFF00; presets[3] = 24'h00FF00;
    presets[4] = 24'h0000FF; presets[5] = 24'h4B0082;
    presets[6] = 24'h800080; presets[7] = 24'hFFFFFF;
  end

  int          m_cnt;
  logic [23:0] m_colour;
  logic [3:0]  m_r, m_g, m_b;
  bit          m_valid = 1'b0;

  function automatic logic [23:0] pick(input logic [7:0] b, input logic [23:0] held);
    for (int i = 0; i < 8; i++)
      if (b[i]) return presets[i];
    return held;
  endfunction

  // Outputs at an edge reflect the counter and colour as they stood before it.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      m_cnt = 0; m_colour = 24'h0; m_r = 0; m_g = 0; m_b = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_r = (m_cnt < int'(m_colour[23:16])) ? 4'hF : 4'h0;
      m_g = (m_cnt < int'(m_colour[15:8]))  ? 4'hF : 4'h0;
      m_b = (m_cnt < int'(m_colour[7:0]))   ? 4'hF : 4'h0;
      m_cnt = (m_cnt + 1) % 256;
      m_colour = pick(btn, m_colour);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("led_R", led_r, m_r);
      check("led_G", led_g, m_g);
      check("led_B", led_b, m_b);
      check("cnt", dut.cnt, m_cnt);
      check("state", dut.state, m_colour);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measure(input string name, input int er, input int eg, input int eb);
    int cr = 0, cg = 0, cb = 0;
    repeat (256) begin
      @(negedge clk);
      cr += int'(led_r[0]); cg += int'(led_g[0]); cb += int'(led_b[0]);
    end
    check({name, "_duty_R"}, cr, er);
    check({name, "_duty_G"}, cg, eg);
    check({name, "_duty_B"}, cb, eb);
  endtask

  task automatic select(input string name, input logic [7:0] b, input logic [23:0] exp_state,
                        input int er, input int eg, input int eb);
    btn = b;
    run(1);
    check({name, "_state"}, dut.state, exp_state);
    run(1023);
    measure(name, er, eg, eb);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    rst = 1'b0;
    btn = 8'h00;
    run(10);
    check("rst_led_R", led_r, 4'h0);
    check("rst_led_G", led_g, 4'h0);
    check("rst_led_B", led_b, 4'h0);
    check("rst_cnt", dut.cnt, 8'd0);
    check("rst_state", dut.state, 24'h0);

    rst = 1'b1;
    run(1);
    check("first_edge_cnt", dut.cnt, 8'd1);
    run(1023);
    measure("idle", 0, 0, 0);

    select("red",    8'h01, 24'hFF0000, 255,   0,   0);
    select("orange", 8'h02, 24'hFF8000, 255, 128,   0);
    select("yellow", 8'h04, 24'hFFFF00, 255, 255,   0);
    select("white",  8'h80, 24'hFFFFFF, 255, 255, 255);
    select("indigo", 8'h60, 24'h4B0082,  75,   0, 130);
    select("purple", 8'hC0, 24'h800080, 128,   0, 128);

    // Priority then hold with buttons released.
    btn = 8'h18;
    run(1);
    check("prio_state", dut.state, 24'h00FF00);
    btn = 8'h00;
    run(1023);
    check("hold_state", dut.state, 24'h00FF00);
    measure("hold", 0, 255, 0);

    // Mid-period reset while white.
    btn = 8'h80;
    run(1);
    btn = 8'h00;
    waited = 0;
    while (m_cnt != 100 && waited < 300) begin
      run(1);
      waited++;
    end
    check("reach_cnt100", dut.cnt, 8'd100);
    check("pre_rst_led_R", led_r, 4'hF);
    rst = 1'b0;
    run(1);
    check("midrst_led_R", led_r, 4'h0);
    check("midrst_led_G", led_g, 4'h0);
    check("midrst_led_B", led_b, 4'h0);
    check("midrst_cnt", dut.cnt, 8'd0);
    check("midrst_state", dut.state, 24'h0);
    rst = 1'b1;
    run(300);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
